// File: rtl/fpu_share_arb_if.sv
// fpu_share_arb_if: requester-side and fpu_core-side signals of the shared FPU arbiter
interface fpu_share_arb_if #(
    parameter int NUM_REQ = 4,
    parameter int C_OP    = 32,
    parameter int C_CMD   = 4,
    parameter int C_RM    = 3,
    parameter int C_FLAGS = 6
);
    logic [NUM_REQ-1:0]         Req_SI, Gnt_SO, RValid_SO, RReady_SI;
    logic [NUM_REQ*C_OP-1:0]    Operand_a_DI, Operand_b_DI, Result_DO;
    logic [NUM_REQ*C_CMD-1:0]   OP_SI;
    logic [NUM_REQ*C_RM-1:0]    RM_SI;
    logic [NUM_REQ*C_FLAGS-1:0] Flags_DO;
    logic                       FPU_Enable_SO, FPU_Valid_SI, Err_SO;
    logic [C_OP-1:0]            FPU_Operand_a_DO, FPU_Operand_b_DO, FPU_Result_DI;
    logic [C_CMD-1:0]           FPU_OP_SO;
    logic [C_RM-1:0]            FPU_RM_SO;
    logic [C_FLAGS-1:0]         FPU_Flags_DI;

    modport master (
        output Req_SI, Operand_a_DI, Operand_b_DI, OP_SI, RM_SI, RReady_SI,
               FPU_Result_DI, FPU_Flags_DI, FPU_Valid_SI,
        input  Gnt_SO, RValid_SO, Result_DO, Flags_DO, Err_SO,
               FPU_Enable_SO, FPU_Operand_a_DO, FPU_Operand_b_DO, FPU_OP_SO, FPU_RM_SO
    );

    modport slave (
        input  Req_SI, Operand_a_DI, Operand_b_DI, OP_SI, RM_SI, RReady_SI,
               FPU_Result_DI, FPU_Flags_DI, FPU_Valid_SI,
        output Gnt_SO, RValid_SO, Result_DO, Flags_DO, Err_SO,
               FPU_Enable_SO, FPU_Operand_a_DO, FPU_Operand_b_DO, FPU_OP_SO, FPU_RM_SO
    );
endinterface

// File: rtl/fpu_share_arb.sv
// fpu_share_arb: round-robin sharing of one fpu_core among NUM_REQ requesters
module fpu_share_arb #(
    parameter int NUM_REQ   = 4,
    parameter int C_OP      = 32,
    parameter int C_CMD     = 4,
    parameter int C_RM      = 3,
    parameter int C_FLAGS   = 6,
    parameter int C_FPU_LAT = 1
) (
    input logic            Clk_CI,
    input logic            Rst_RBI,
    fpu_share_arb_if.slave bus
);
    localparam int IW = $clog2(NUM_REQ);

    logic [IW-1:0]                ptr_q, ptr_d, gidx, idx, tail_id;
    logic [IW:0]                  sum;
    logic                         found, tail_v, err_q, err_d;
    logic [NUM_REQ-1:0]           elig, gnt, inflight_q, inflight_d, rvalid_q, rvalid_d;
    logic [NUM_REQ*C_OP-1:0]      res_q, res_d;
    logic [NUM_REQ*C_FLAGS-1:0]   flg_q, flg_d;
    logic [C_FPU_LAT-1:0]         pv_q, pv_d;
    logic [C_FPU_LAT-1:0][IW-1:0] pid_q, pid_d;

    assign tail_v  = pv_q[C_FPU_LAT-1];
    assign tail_id = pid_q[C_FPU_LAT-1];

    // Scan for the first eligible requester from ptr_q and route it onto the FPU; grants are held off during reset
    always_comb begin
        elig  = bus.Req_SI & ~inflight_q & ~rvalid_q & {NUM_REQ{Rst_RBI}};
        found = 1'b0;
        gidx  = '0;
        idx   = '0;
        sum   = '0;
        gnt   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, ptr_q} + (IW+1)'(k);
            idx = (sum >= (IW+1)'(NUM_REQ)) ? IW'(sum - (IW+1)'(NUM_REQ)) : sum[IW-1:0];
            if (!found && elig[idx]) begin
                found = 1'b1;
                gidx  = idx;
            end
        end
        if (found) gnt[gidx] = 1'b1;
        bus.Gnt_SO           = gnt;
        bus.FPU_Enable_SO    = found;
        bus.FPU_Operand_a_DO = '0;
        bus.FPU_Operand_b_DO = '0;
        bus.FPU_OP_SO        = '0;
        bus.FPU_RM_SO        = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                bus.FPU_Operand_a_DO = bus.Operand_a_DI[i*C_OP +: C_OP];
                bus.FPU_Operand_b_DO = bus.Operand_b_DI[i*C_OP +: C_OP];
                bus.FPU_OP_SO        = bus.OP_SI[i*C_CMD +: C_CMD];
                bus.FPU_RM_SO        = bus.RM_SI[i*C_RM +: C_RM];
            end
        end
        ptr_d = found ? ((gidx == IW'(NUM_REQ-1)) ? '0 : gidx + 1'b1) : ptr_q;
    end

    // Shift the ID pipeline, write back the tail into its slot, release consumed slots, flag protocol errors
    always_comb begin
        pv_d     = (pv_q << 1) | C_FPU_LAT'(found);
        pid_d    = pid_q;
        pid_d[0] = gidx;
        for (int k = 1; k < C_FPU_LAT; k++) pid_d[k] = pid_q[k-1];
        inflight_d = inflight_q | gnt;
        rvalid_d   = rvalid_q & ~bus.RReady_SI;
        res_d      = res_q;
        flg_d      = flg_q;
        err_d      = err_q | (tail_v ^ bus.FPU_Valid_SI);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (tail_v && tail_id == IW'(i)) begin
                inflight_d[i]                 = 1'b0;
                rvalid_d[i]                   = 1'b1;
                res_d[i*C_OP +: C_OP]         = bus.FPU_Result_DI;
                flg_d[i*C_FLAGS +: C_FLAGS]   = bus.FPU_Flags_DI;
            end
        end
    end

    // State registers
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            ptr_q      <= '0;
            inflight_q <= '0;
            rvalid_q   <= '0;
            res_q      <= '0;
            flg_q      <= '0;
            pv_q       <= '0;
            pid_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            ptr_q      <= ptr_d;
            inflight_q <= inflight_d;
            rvalid_q   <= rvalid_d;
            res_q      <= res_d;
            flg_q      <= flg_d;
            pv_q       <= pv_d;
            pid_q      <= pid_d;
            err_q      <= err_d;
        end
    end

    assign bus.RValid_SO = rvalid_q;
    assign bus.Result_DO = res_q;
    assign bus.Flags_DO  = flg_q;
    assign bus.Err_SO    = err_q;
endmodule

// File: tb/tb_fpu_share_arb.sv
// tb_fpu_share_arb: scenario tasks plus a response scoreboard against a LAT=1 adder FPU model
module tb_fpu_share_arb;
    logic clk = 1'b0, rst_n = 1'b0, kill = 1'b0, stray = 1'b0;
    int passed = 0, total = 0;
    logic [3:0] prev = '0;

    typedef struct { int id; logic [31:0] res; logic [5:0] flg; } exp_t;
    exp_t sb[$];
    exp_t me;

    fpu_share_arb_if b ();
    fpu_share_arb dut (.Clk_CI(clk), .Rst_RBI(rst_n), .bus(b));

    always #5 clk = ~clk;

    // FPU model: one-cycle adder with constant flags, optional dropped or stray valid
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b.FPU_Valid_SI  <= 1'b0;
            b.FPU_Result_DI <= '0;
            b.FPU_Flags_DI  <= '0;
        end else begin
            b.FPU_Valid_SI  <= (b.FPU_Enable_SO & ~kill) | stray;
            b.FPU_Result_DI <= b.FPU_Operand_a_DO + b.FPU_Operand_b_DO;
            b.FPU_Flags_DI  <= 6'b000100;
        end
    end

    // Response monitor: each rising RValid pops the scoreboard
    always @(negedge clk) begin
        #2;
        if (!rst_n) prev = '0;
        else begin
            for (int i = 0; i < 4; i++) begin
                if (b.RValid_SO[i] && !prev[i]) begin
                    total++;
                    if (sb.size() == 0) $display("FAIL resp_unexpected req%0d got rvalid exp none", i);
                    else begin
                        me = sb.pop_front();
                        if (me.id != i || b.Result_DO[i*32 +: 32] !== me.res || b.Flags_DO[i*6 +: 6] !== me.flg)
                            $display("FAIL resp req%0d got res=%h flg=%b exp id=%0d res=%h flg=%b",
                                     i, b.Result_DO[i*32 +: 32], b.Flags_DO[i*6 +: 6], me.id, me.res, me.flg);
                        else passed++;
                    end
                end
            end
            prev = b.RValid_SO;
        end
    end

    task automatic req_op(input int i, input logic [31:0] a, input logic [31:0] c);
        b.Operand_a_DI[i*32 +: 32] = a;
        b.Operand_b_DI[i*32 +: 32] = c;
        b.OP_SI[i*4 +: 4] = 4'(i + 3);
        b.RM_SI[i*3 +: 3] = 3'(i);
        sb.push_back('{id: i, res: a + c, flg: 6'b000100});
    endtask

    task automatic test_reset;
        b.Req_SI = 4'b1111;
        req_op(0, 32'h10, 32'h20);
        repeat (3) @(negedge clk);
        #1;
        total++; if (b.Gnt_SO !== 4'b0000) $display("FAIL reset_gnt got=%b exp=0000", b.Gnt_SO); else passed++;
        total++; if (b.FPU_Enable_SO !== 1'b0) $display("FAIL reset_en got=%b exp=0", b.FPU_Enable_SO); else passed++;
        total++; if (b.RValid_SO !== 4'b0000) $display("FAIL reset_rvalid got=%b exp=0000", b.RValid_SO); else passed++;
        total++; if (b.Err_SO !== 1'b0) $display("FAIL reset_err got=%b exp=0", b.Err_SO); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++; if (b.Gnt_SO !== 4'b0001) $display("FAIL reset_first_gnt got=%b exp=0001", b.Gnt_SO); else passed++;
        @(negedge clk);
        b.Req_SI = 4'b0000;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_single;
        req_op(1, 32'h5, 32'h7);
        b.Req_SI = 4'b0010;
        #1;
        total++; if (b.Gnt_SO !== 4'b0010) $display("FAIL single_gnt got=%b exp=0010", b.Gnt_SO); else passed++;
        total++; if (b.FPU_Enable_SO !== 1'b1) $display("FAIL single_en got=%b exp=1", b.FPU_Enable_SO); else passed++;
        total++; if (b.FPU_Operand_a_DO !== 32'h5 || b.FPU_OP_SO !== 4'd4 || b.FPU_RM_SO !== 3'd1)
            $display("FAIL single_mux got a=%h op=%h rm=%h exp a=5 op=4 rm=1", b.FPU_Operand_a_DO, b.FPU_OP_SO, b.FPU_RM_SO);
        else passed++;
        @(negedge clk);
        b.Req_SI = 4'b0000;
        #1;
        total++; if (b.FPU_Enable_SO !== 1'b0 || b.FPU_Operand_a_DO !== 32'h0 || b.FPU_Operand_b_DO !== 32'h0)
            $display("FAIL single_silence got en=%b a=%h b=%h exp 0", b.FPU_Enable_SO, b.FPU_Operand_a_DO, b.FPU_Operand_b_DO);
        else passed++;
        total++; if (b.RValid_SO !== 4'b0000) $display("FAIL single_early got=%b exp=0000", b.RValid_SO); else passed++;
        @(negedge clk);
        #1;
        total++; if (b.RValid_SO !== 4'b0010 || b.Result_DO[63:32] !== 32'hC || b.Flags_DO[11:6] !== 6'b000100)
            $display("FAIL single_resp got rv=%b res=%h flg=%b exp 0010 0000000c 000100", b.RValid_SO, b.Result_DO[63:32], b.Flags_DO[11:6]);
        else passed++;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_fairness;
        req_op(3, 32'h100, 32'h1);
        req_op(0, 32'h200, 32'h2);
        b.Req_SI = 4'b1001;
        #1;
        total++; if (b.Gnt_SO !== 4'b1000) $display("FAIL fair_first got=%b exp=1000", b.Gnt_SO); else passed++;
        @(negedge clk);
        b.Req_SI = 4'b0001;
        #1;
        total++; if (b.Gnt_SO !== 4'b0001) $display("FAIL fair_second got=%b exp=0001", b.Gnt_SO); else passed++;
        @(negedge clk);
        b.Req_SI = 4'b0000;
        repeat (3) @(negedge clk);
        req_op(1, 32'h300, 32'h3);
        req_op(3, 32'h400, 32'h4);
        b.Req_SI = 4'b1010;
        #1;
        total++; if (b.Gnt_SO !== 4'b0010) $display("FAIL fair_ptr1 got=%b exp=0010", b.Gnt_SO); else passed++;
        @(negedge clk);
        b.Req_SI = 4'b1000;
        #1;
        total++; if (b.Gnt_SO !== 4'b1000) $display("FAIL fair_ptr3 got=%b exp=1000", b.Gnt_SO); else passed++;
        @(negedge clk);
        b.Req_SI = 4'b0000;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_back_to_back;
        logic [3:0] eg;
        for (int i = 0; i < 4; i++) req_op(i, $urandom, $urandom);
        b.Req_SI = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            #1;
            eg = 4'b0001 << (k % 4);
            total++; if (b.Gnt_SO !== eg) $display("FAIL b2b_gnt%0d got=%b exp=%b", k, b.Gnt_SO, eg); else passed++;
            @(negedge clk);
            if (k == 0) req_op(0, $urandom, $urandom);
            else b.Req_SI[k % 4] = 1'b0;
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_backpressure;
        b.RReady_SI[0] = 1'b0;
        req_op(0, 32'h11, 32'h22);
        b.Req_SI = 4'b0001;
        #1;
        total++; if (b.Gnt_SO !== 4'b0001) $display("FAIL bp_gnt0 got=%b exp=0001", b.Gnt_SO); else passed++;
        @(negedge clk);
        for (int i = 1; i < 4; i++) req_op(i, 32'(i * 16), 32'h5);
        req_op(0, 32'h33, 32'h44);
        b.Req_SI = 4'b1111;
        for (int k = 1; k < 4; k++) begin
            #1;
            total++; if (b.Gnt_SO !== 4'(1 << k)) $display("FAIL bp_gnt%0d got=%b exp=%b", k, b.Gnt_SO, 4'(1 << k)); else passed++;
            @(negedge clk);
            b.Req_SI[k] = 1'b0;
        end
        #1;
        total++; if (b.Gnt_SO !== 4'b0000 || b.RValid_SO[0] !== 1'b1)
            $display("FAIL bp_hold got gnt=%b rv0=%b exp gnt=0000 rv0=1", b.Gnt_SO, b.RValid_SO[0]);
        else passed++;
        @(negedge clk);
        b.RReady_SI[0] = 1'b1;
        #1;
        total++; if (b.Gnt_SO !== 4'b0000) $display("FAIL bp_nobypass got=%b exp=0000", b.Gnt_SO); else passed++;
        @(negedge clk);
        #1;
        total++; if (b.Gnt_SO !== 4'b0001) $display("FAIL bp_regrant got=%b exp=0001", b.Gnt_SO); else passed++;
        @(negedge clk);
        b.Req_SI = 4'b0000;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_stray;
        stray = 1'b1;
        #1;
        total++; if (b.Err_SO !== 1'b0) $display("FAIL stray_pre_err got=%b exp=0", b.Err_SO); else passed++;
        @(negedge clk);
        stray = 1'b0;
        @(negedge clk);
        #1;
        total++; if (b.Err_SO !== 1'b1) $display("FAIL stray_err got=%b exp=1", b.Err_SO); else passed++;
        total++; if (b.RValid_SO !== 4'b0000) $display("FAIL stray_nowrite got=%b exp=0000", b.RValid_SO); else passed++;
        @(negedge clk);
        #1;
        total++; if (b.RValid_SO !== 4'b0000) $display("FAIL stray_nowrite2 got=%b exp=0000", b.RValid_SO); else passed++;
    endtask

    task automatic test_mid_reset;
        @(negedge clk);
        b.Req_SI = 4'b0011;
        #1;
        total++; if (b.FPU_Enable_SO !== 1'b1) $display("FAIL mrst_issue got=%b exp=1", b.FPU_Enable_SO); else passed++;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++; if (b.Gnt_SO !== 4'b0000 || b.FPU_Enable_SO !== 1'b0 || b.RValid_SO !== 4'b0000 || b.Err_SO !== 1'b0)
            $display("FAIL mrst_state got gnt=%b en=%b rv=%b err=%b exp all 0", b.Gnt_SO, b.FPU_Enable_SO, b.RValid_SO, b.Err_SO);
        else passed++;
        b.Req_SI = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            total++; if (b.RValid_SO !== 4'b0000) $display("FAIL mrst_spurious%0d got=%b exp=0000", k, b.RValid_SO); else passed++;
            @(negedge clk);
        end
    endtask

    task automatic test_kill;
        req_op(2, 32'hABC, 32'h111);
        b.Req_SI = 4'b0100;
        kill = 1'b1;
        #1;
        total++; if (b.Gnt_SO !== 4'b0100) $display("FAIL kill_gnt got=%b exp=0100", b.Gnt_SO); else passed++;
        @(negedge clk);
        kill = 1'b0;
        b.Req_SI = 4'b0000;
        #1;
        total++; if (b.Err_SO !== 1'b0) $display("FAIL kill_early_err got=%b exp=0", b.Err_SO); else passed++;
        @(negedge clk);
        #1;
        total++; if (b.Err_SO !== 1'b1 || b.RValid_SO[2] !== 1'b1)
            $display("FAIL kill_err got err=%b rv2=%b exp 1 1", b.Err_SO, b.RValid_SO[2]);
        else passed++;
        repeat (3) @(negedge clk);
        #1;
        total++; if (b.Err_SO !== 1'b1) $display("FAIL kill_sticky got=%b exp=1", b.Err_SO); else passed++;
    endtask

    initial begin
        b.Req_SI       = '0;
        b.RReady_SI    = '1;
        b.Operand_a_DI = '0;
        b.Operand_b_DI = '0;
        b.OP_SI        = '0;
        b.RM_SI        = '0;
        test_reset;
        test_single;
        test_fairness;
        test_back_to_back;
        test_backpressure;
        test_stray;
        test_mid_reset;
        test_kill;
        repeat (4) @(negedge clk);
        total++; if (sb.size() != 0) $display("FAIL sb_drain got=%0d pending exp=0", sb.size()); else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
